// File: rtl/fir_pkg.sv
// Shared types and width helpers for the time-multiplexed FIR bank.
package fir_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_MAC   = 2'd2,
        ST_OUT   = 2'd3
    } fir_state_e;

    function automatic int ch_w(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

    function automatic int acc_w(input int data_w, input int coef_w, input int taps);
        return data_w + coef_w + $clog2(taps);
    endfunction

    function automatic int rnd_shift(input int coef_w, input int coef_mag);
        return coef_w - 1 - coef_mag;
    endfunction

    // Half-LSB of the post-shift result, added before the arithmetic shift.
    function automatic longint rnd_const(input int shift);
        return 64'sd1 <<< (shift - 1);
    endfunction

endpackage

// File: rtl/fir_tm_bank_if.sv
// Sample-in / result-out streaming bundle; the slave modport is the filter side.
interface fir_tm_bank_if #(
    parameter int DATA_W = 14,
    parameter int CH_W   = 1
);
    logic                     s_valid;
    logic                     s_ready;
    logic signed [DATA_W-1:0] s_data;
    logic [CH_W-1:0]          s_ch;
    logic                     m_valid;
    logic                     m_ready;
    logic signed [DATA_W-1:0] m_data;
    logic [CH_W-1:0]          m_ch;

    modport master (
        output s_valid, s_data, s_ch, m_ready,
        input  s_ready, m_valid, m_data, m_ch
    );

    modport slave (
        input  s_valid, s_data, s_ch, m_ready,
        output s_ready, m_valid, m_data, m_ch
    );
endinterface

// File: rtl/fir_delay_ram.sv
// Per-channel circular sample history; rd_data walks from newest to oldest.
module fir_delay_ram #(
    parameter int DATA_W = 14,
    parameter int TAPS   = 8,
    parameter int NCH    = 2,
    parameter int CH_W   = 1,
    parameter int ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr_en,
    input  logic [CH_W-1:0]          clr_ch,
    input  logic [ADDR_W-1:0]        clr_tap,
    input  logic                     wr_en,
    input  logic [CH_W-1:0]          wr_ch,
    input  logic signed [DATA_W-1:0] wr_data,
    input  logic                     rd_step,
    input  logic [CH_W-1:0]          rd_ch,
    output logic signed [DATA_W-1:0] rd_data
);

    logic signed [DATA_W-1:0] mem_r  [NCH][TAPS];
    logic [ADDR_W-1:0]        wptr_r [NCH];
    logic [ADDR_W-1:0]        rptr_r;

    function automatic logic [ADDR_W-1:0] tap_inc(input logic [ADDR_W-1:0] p);
        if (p == ADDR_W'(TAPS - 1)) return '0;
        else                        return p + ADDR_W'(1);
    endfunction

    function automatic logic [ADDR_W-1:0] tap_dec(input logic [ADDR_W-1:0] p);
        if (p == '0) return ADDR_W'(TAPS - 1);
        else         return p - ADDR_W'(1);
    endfunction

    // Sample storage: zero-filled entry by entry during clear, otherwise newest sample at wptr.
    always_ff @(posedge clk) begin
        if (clr_en) begin
            mem_r[clr_ch][clr_tap] <= '0;
        end else if (wr_en) begin
            mem_r[wr_ch][wptr_r[wr_ch]] <= wr_data;
        end
    end

    // Pointers: read pointer starts on the slot just written and steps back one tap per product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) wptr_r[i] <= '0;
            rptr_r <= '0;
        end else if (wr_en) begin
            wptr_r[wr_ch] <= tap_inc(wptr_r[wr_ch]);
            rptr_r        <= wptr_r[wr_ch];
        end else if (rd_step) begin
            rptr_r <= tap_dec(rptr_r);
        end
    end

    assign rd_data = mem_r[rd_ch][rptr_r];

endmodule

// File: rtl/fir_tm_bank.sv
// Time-multiplexed FIR: NCH channels share one MAC and a double-buffered coefficient set.
// Define FIR_TM_BANK_SAT_EN to clamp the output; by default the result wraps to DATA_W bits.
module fir_tm_bank
    import fir_pkg::*;
#(
    parameter int DATA_W   = 14,
    parameter int COEF_W   = 18,
    parameter int COEF_MAG = 0,
    parameter int TAPS     = 8,
    parameter int NCH      = 2
) (
    input  logic                       fir_clk,
    input  logic                       fir_aresetn,
    fir_tm_bank_if.slave               bus,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_wdata,
    input  logic                       coef_commit,
    output logic                       commit_pending,
    output logic                       bank_sel,
    output logic                       busy
);

    localparam int CH_W   = ch_w(NCH);
    localparam int ADDR_W = $clog2(TAPS);
    localparam int CNT_W  = ADDR_W + 1;
    localparam int ACC_W  = acc_w(DATA_W, COEF_W, TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int SHIFT  = rnd_shift(COEF_W, COEF_MAG);
    localparam logic signed [ACC_W-1:0] RND_C   = ACC_W'(rnd_const(SHIFT));
    localparam logic [CNT_W-1:0]        CNT_TAPS = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(TAPS + 1);

    fir_state_e               state_r, state_s;
    logic                     s_ready_r, busy_r, bank_sel_r, pending_r;
    logic [CH_W-1:0]          clr_ch_r, ch_r, m_ch_r;
    logic [ADDR_W-1:0]        clr_tap_r;
    logic [CNT_W-1:0]         cnt_r;
    logic signed [PROD_W-1:0] prod_r, prod_s;
    logic signed [ACC_W-1:0]  acc_r, rnd_s;
    logic                     m_valid_r;
    logic signed [DATA_W-1:0] m_data_r, out_s, rd_data_s;
    logic signed [COEF_W-1:0] coef_mem_r [2][TAPS];
    logic signed [COEF_W-1:0] coef_rd_s;
    logic                     hs_s, ch_ok_s, wr_en_s, clr_en_s, clr_last_s;
    logic                     mul_en_s, acc_en_s, fin_s, swap_s;

    if (NCH == (1 << CH_W)) begin : g_ch_full
        assign ch_ok_s = 1'b1;
    end else begin : g_ch_part
        assign ch_ok_s = (32'(bus.s_ch) < 32'(NCH));
    end

    assign hs_s       = bus.s_valid & s_ready_r;
    assign wr_en_s    = hs_s & ch_ok_s;
    assign clr_en_s   = (state_r == ST_CLEAR);
    assign clr_last_s = (clr_ch_r == CH_W'(NCH - 1)) && (clr_tap_r == ADDR_W'(TAPS - 1));
    assign mul_en_s   = (state_r == ST_MAC) && (cnt_r < CNT_TAPS);
    assign acc_en_s   = (state_r == ST_MAC) && (cnt_r != '0) && (cnt_r <= CNT_TAPS);
    assign fin_s      = (state_r == ST_MAC) && (cnt_r == CNT_LAST);
    assign swap_s     = (state_r == ST_IDLE) && pending_r;

    fir_delay_ram #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .NCH    (NCH),
        .CH_W   (CH_W),
        .ADDR_W (ADDR_W)
    ) u_dly (
        .clk     (fir_clk),
        .rst_n   (fir_aresetn),
        .clr_en  (clr_en_s),
        .clr_ch  (clr_ch_r),
        .clr_tap (clr_tap_r),
        .wr_en   (wr_en_s),
        .wr_ch   (bus.s_ch),
        .wr_data (bus.s_data),
        .rd_step (mul_en_s),
        .rd_ch   (ch_r),
        .rd_data (rd_data_s)
    );

    assign coef_rd_s = coef_mem_r[bank_sel_r][cnt_r[ADDR_W-1:0]];
    assign prod_s    = PROD_W'(coef_rd_s) * PROD_W'(rd_data_s);
    assign rnd_s     = acc_r + RND_C;

`ifdef FIR_TM_BANK_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(64'sd1 <<< (DATA_W - 1)));
    logic signed [ACC_W-1:0] shf_s;
    assign shf_s = rnd_s >>> SHIFT;

    // Output clamp to the DATA_W signed range.
    always_comb begin
        if (shf_s > SAT_MAX) begin
            out_s = SAT_MAX[DATA_W-1:0];
        end else if (shf_s < SAT_MIN) begin
            out_s = SAT_MIN[DATA_W-1:0];
        end else begin
            out_s = shf_s[DATA_W-1:0];
        end
    end
`else
    // Output keeps the low DATA_W bits of the rounded, shifted accumulator.
    always_comb begin
        out_s = DATA_W'(rnd_s >>> SHIFT);
    end
`endif

    // Next-state decode.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_CLEAR: begin
                if (clr_last_s) state_s = ST_IDLE;
                else            state_s = ST_CLEAR;
            end
            ST_IDLE: begin
                if (wr_en_s) state_s = ST_MAC;
                else         state_s = ST_IDLE;
            end
            ST_MAC: begin
                if (fin_s) state_s = ST_OUT;
                else       state_s = ST_MAC;
            end
            ST_OUT: begin
                if (bus.m_ready) state_s = ST_IDLE;
                else             state_s = ST_OUT;
            end
            default: state_s = ST_CLEAR;
        endcase
    end

    // State register.
    always_ff @(posedge fir_clk or negedge fir_aresetn) begin
        if (!fir_aresetn) state_r <= ST_CLEAR;
        else              state_r <= state_s;
    end

    // Control flops: handshake flags, clear sweep and bank selection.
    always_ff @(posedge fir_clk or negedge fir_aresetn) begin
        if (!fir_aresetn) begin
            s_ready_r  <= 1'b0;
            busy_r     <= 1'b1;
            bank_sel_r <= 1'b0;
            pending_r  <= 1'b0;
            clr_ch_r   <= '0;
            clr_tap_r  <= '0;
        end else begin
            s_ready_r <= (state_s == ST_IDLE);
            busy_r    <= (state_s != ST_IDLE);
            if (swap_s) begin
                bank_sel_r <= ~bank_sel_r;
                pending_r  <= 1'b0;
            end else if (coef_commit) begin
                pending_r <= 1'b1;
            end
            if (clr_en_s) begin
                if (clr_tap_r == ADDR_W'(TAPS - 1)) begin
                    clr_tap_r <= '0;
                    clr_ch_r  <= clr_ch_r + CH_W'(1);
                end else begin
                    clr_tap_r <= clr_tap_r + ADDR_W'(1);
                end
            end
        end
    end

    // MAC pipeline: product register feeds the accumulator one cycle later.
    always_ff @(posedge fir_clk or negedge fir_aresetn) begin
        if (!fir_aresetn) begin
            cnt_r     <= '0;
            acc_r     <= '0;
            prod_r    <= '0;
            ch_r      <= '0;
            m_valid_r <= 1'b0;
            m_data_r  <= '0;
            m_ch_r    <= '0;
        end else begin
            if (wr_en_s) begin
                cnt_r <= '0;
                acc_r <= '0;
                ch_r  <= bus.s_ch;
            end else if (state_r == ST_MAC) begin
                cnt_r <= cnt_r + CNT_W'(1);
                if (mul_en_s) prod_r <= prod_s;
                if (acc_en_s) acc_r  <= acc_r + ACC_W'(prod_r);
            end
            if (fin_s) begin
                m_valid_r <= 1'b1;
                m_data_r  <= out_s;
                m_ch_r    <= ch_r;
            end else if ((state_r == ST_OUT) && bus.m_ready) begin
                m_valid_r <= 1'b0;
            end
        end
    end

    // Coefficient write port always targets the bank not currently in use.
    always_ff @(posedge fir_clk) begin
        if (coef_we) coef_mem_r[~bank_sel_r][coef_addr] <= coef_wdata;
    end

    assign bus.s_ready     = s_ready_r;
    assign bus.m_valid     = m_valid_r;
    assign bus.m_data      = m_data_r;
    assign bus.m_ch        = m_ch_r;
    assign commit_pending  = pending_r;
    assign bank_sel        = bank_sel_r;
    assign busy            = busy_r;

endmodule

// File: doc/fir_tm_bank.md
FIR_TM_BANK -- requirements
Module: fir_tm_bank

Interface
REQ-001 SHALL have parameter DATA_W, default 14, signed sample width.
REQ-002 SHALL have parameter COEF_W, default 18, signed Q1.(COEF_W-1) coefficient width.
REQ-003 SHALL have parameter COEF_MAG, default 0, output gain shift in bits, 0 to COEF_W-2.
REQ-004 SHALL have parameter TAPS, default 8, taps per channel, at least 2.
REQ-005 SHALL have parameter NCH, default 2, independent channels sharing one coefficient set, at least 1.
REQ-006 SHALL have ports: fir_clk  in  1  clock; fir_aresetn  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have ports: s_valid in 1; s_ready out 1; s_data in DATA_W signed sample; s_ch in CH_W channel index, where CH_W = max(1, clog2(NCH)).
REQ-008 SHALL have ports: m_valid out 1; m_ready in 1; m_data out DATA_W filtered sample; m_ch out CH_W channel of m_data.
REQ-009 SHALL have ports: coef_we in 1; coef_addr in clog2(TAPS); coef_wdata in COEF_W; coef_commit in 1; commit_pending out 1; bank_sel out 1 active bank; busy out 1.

Function
REQ-010 SHALL implement four states: CLEAR, IDLE, MAC, OUT.
REQ-011 CLEAR SHALL write zero to all NCH*TAPS delay-line entries, one per cycle, then go to IDLE.
REQ-012 s_ready SHALL be 1 only in IDLE; busy SHALL be 1 in any state other than IDLE.
REQ-013 A handshake (s_valid & s_ready) SHALL write s_data into the delay line of channel s_ch at that channel's write pointer, latch s_ch, and enter MAC.
REQ-014 The write pointer SHALL wrap from TAPS-1 to 0, independently per channel.
REQ-015 s_ch >= NCH SHALL be accepted and the sample dropped; no output SHALL be produced for it.
REQ-016 MAC SHALL accumulate coef[k]*x[n-k] for k = 0..TAPS-1, one product per cycle, using the active bank.
REQ-017 m_valid SHALL rise exactly TAPS+2 cycles after the accept edge.
REQ-018 The accumulator SHALL be DATA_W+COEF_W+clog2(TAPS) bits, signed, and SHALL never overflow.
REQ-019 m_data SHALL be the accumulator plus 2^(S-1), arithmetically shifted right by S, where S = COEF_W-1-COEF_MAG (round half up).
REQ-020 In OUT, m_valid, m_data and m_ch SHALL be held stable until m_ready; on the handshake edge the block SHALL go to IDLE.
REQ-021 coef_we SHALL write coef_wdata to the inactive bank at coef_addr in any state, and SHALL never modify the active bank.
REQ-022 coef_commit SHALL set commit_pending.
REQ-023 At a clock edge where state is IDLE and commit_pending is 1, the block SHALL toggle bank_sel and clear commit_pending; a sample accepted on that same edge SHALL use the new bank.
REQ-024 A coef_we coinciding with a swap edge SHALL land in the bank becoming active.
REQ-025 A coef_commit while commit_pending is already 1 SHALL have no additional effect.

Reset
REQ-026 Asserting reset SHALL force state CLEAR, and SHALL set m_valid=0, m_data=0, m_ch=0, s_ready=0, busy=1, commit_pending=0, bank_sel=0, and all write pointers to 0.
REQ-027 Reset SHALL NOT clear coefficient banks; their contents are undefined until written.
REQ-028 Reset asserted mid-MAC or mid-OUT SHALL discard the in-flight result, with no m_valid pulse afterward.

Configuration
REQ-029 With FIR_TM_BANK_SAT_EN defined, m_data SHALL clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-030 Without FIR_TM_BANK_SAT_EN defined, m_data SHALL be the low DATA_W bits of the shifted value (wrap).

Structure
REQ-031 Package fir_pkg SHALL hold the state enum, the CH_W/ACC_W width functions, and the rounding-shift constant helper.
REQ-032 The per-channel circular delay line, with its read and write pointers, SHALL be sub-module fir_delay_ram.

Verification (TAPS=4, NCH=2, DATA_W=14, COEF_W=18, COEF_MAG=0)
REQ-033 Impulse: coef = {65536, 32768, 0, 0}, commit, then ch0 samples 1000, 0, 0 -> m_data 500, 250, 0; m_valid 6 cycles after each accept.
REQ-034 Channel isolation: ch0 sample 1000, then ch1 sample 2000 -> ch1 m_data 1000 with m_ch=1; ch0 history unaffected.
REQ-035 Bank swap: write new coefs and commit while in MAC -> current result uses the old bank, next sample uses the new bank, bank_sel toggles once.
REQ-036 Saturation: all coefs 131071, four ch0 samples of 8191 -> 4th m_data = 8191 with macro defined, low 14 bits of the unclamped value without it.
REQ-037 Backpressure and reset: hold m_ready=0 for 10 cycles -> m_data stable and s_ready=0; assert reset in MAC -> outputs at reset values, CLEAR lasts 8 cycles, then s_ready=1.
